// File: rtl/pipe_skid_latch.sv
// -----------------------------------------------------------------------------
// pipe_skid_latch
//
// Single-stage valid/ready pipeline register with one skid entry. The main
// register drives out_data. The skid register catches the one extra payload
// that can arrive while downstream is stalled. in_ready is decoded from the
// registered state only, so there is no combinational path from out_ready
// back to in_ready.
//
// Parameters
//   DATA_W      payload width
//   CNT_W       width of each performance counter
//
// Ports
//   CLK         clock; all state updates on the rising edge
//   nRST        asynchronous active-low reset
//   in_valid    upstream offers in_data
//   in_ready    stage can accept (state EMPTY or ONE)
//   in_data     upstream payload
//   flush       synchronous squash of all held payload
//   out_valid   out_data holds a payload (state ONE or FULL)
//   out_ready   downstream accepts out_data
//   out_data    payload to downstream; zero while out_valid is low
//   stall_cnt   saturating count of cycles with out_valid && !out_ready
//   bubble_cnt  saturating count of cycles with !out_valid
//
// Build option
//   PIPE_SKID_LATCH_PERF_EN  when defined, stall_cnt/bubble_cnt are live
//                            saturating counters; otherwise both ports are
//                            tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module pipe_skid_latch #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_p0;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_p0;
    logic [DATA_W-1:0] main_nxt;
    logic [DATA_W-1:0] skid_p0;
    logic [DATA_W-1:0] skid_nxt;

    logic vld_p0;
    logic in_fire;
    logic out_fire;

    // Handshake decode: both flags come from the registered state only.
    assign vld_p0    = (state_p0 == ONE) || (state_p0 == FULL);
    assign in_ready  = (state_p0 == EMPTY) || (state_p0 == ONE);
    assign out_valid = vld_p0;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_p0 && out_ready;

    // main is cleared whenever the stage empties, so it can drive out_data
    // directly and still read as zero while out_valid is low.
    assign out_data = main_p0;

    // ---- stage p0: state and storage registers ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_p0 <= EMPTY;
            main_p0  <= '0;
            skid_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            main_p0  <= main_nxt;
            skid_p0  <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        main_nxt  = main_p0;
        skid_nxt  = skid_p0;

        if (flush) begin
            // Flush wins over everything: an accepted input is discarded and
            // an output handshake in this cycle counts as delivered.
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end else if (in_fire) begin
                        state_nxt = FULL;
                        skid_nxt  = in_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                        main_nxt  = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_nxt = ONE;
                        main_nxt  = skid_p0;
                        skid_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_LATCH_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&cnt) ? cnt : cnt + one;
    endfunction

    logic [CNT_W-1:0] stall_p0;
    logic [CNT_W-1:0] bubble_p0;

    // ---- stage p0: performance counters (independent of flush) ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_p0  <= '0;
            bubble_p0 <= '0;
        end else begin
            if (vld_p0 && !out_ready) begin
                stall_p0 <= sat_inc(stall_p0);
            end
            if (!vld_p0) begin
                bubble_p0 <= sat_inc(bubble_p0);
            end
        end
    end

    assign stall_cnt  = stall_p0;
    assign bubble_cnt = bubble_p0;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
module tb_pipe_skid_latch;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 21;

    logic              CLK;
    logic              nRST;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks;
    int failures;

    pipe_skid_latch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        ir;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic ov, input logic [31:0] od, input logic ir);
        check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({name, ".out_data"}, out_data, od);
        check({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    endtask

    // One clock edge, then settle just past it before sampling or driving.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Each row: inputs applied for one cycle, outputs expected after the edge.
        vecs[0]  = '{1'b1, 32'h11,       1'b1, 1'b0, 1'b1, 32'h11,       1'b1};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[2]  = '{1'b1, 32'hA1,       1'b0, 1'b0, 1'b1, 32'hA1,       1'b1};
        vecs[3]  = '{1'b1, 32'hA2,       1'b0, 1'b0, 1'b1, 32'hA1,       1'b0};
        vecs[4]  = '{1'b1, 32'hA3,       1'b0, 1'b0, 1'b1, 32'hA1,       1'b0};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA2,       1'b1};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'hB1,       1'b0, 1'b0, 1'b1, 32'hB1,       1'b1};
        vecs[8]  = '{1'b1, 32'hB2,       1'b0, 1'b0, 1'b1, 32'hB1,       1'b0};
        vecs[9]  = '{1'b1, 32'hB3,       1'b1, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{1'b1, 32'hC1,       1'b1, 1'b0, 1'b1, 32'hC1,       1'b1};
        vecs[12] = '{1'b1, 32'hC2,       1'b1, 1'b0, 1'b1, 32'hC2,       1'b1};
        vecs[13] = '{1'b1, 32'hC3,       1'b0, 1'b0, 1'b1, 32'hC2,       1'b0};
        vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hC2,       1'b0};
        vecs[15] = '{1'b1, 32'hC4,       1'b1, 1'b0, 1'b1, 32'hC3,       1'b1};
        vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hC3,       1'b1};
        vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[18] = '{1'b1, 32'hD1,       1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[19] = '{1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[20] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1};

        // Reset values are visible while nRST is still low.
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        check_outs("reset", 1'b0, 32'h0, 1'b1);
        check("reset.stall_cnt",  {28'd0, stall_cnt},  32'h0);
        check("reset.bubble_cnt", {28'd0, bubble_cnt}, 32'h0);
        step();
        nRST = 1'b1;

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].ir);
        end

        // Streaming: one payload per cycle, one-cycle latency, never back-pressured.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 32'(k), 1'b1, 1'b0);
            step();
            check_outs($sformatf("stream%0d", k), 1'b1, 32'(k), 1'b1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_outs("stream_end", 1'b0, 32'h0, 1'b1);

        // Reset while FULL: everything held is lost, outputs clear without a clock.
        drive(1'b1, 32'hE1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hE2, 1'b0, 1'b0);
        step();
        check_outs("pre_rst_full", 1'b1, 32'hE1, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        check_outs("mid_rst", 1'b0, 32'h0, 1'b1);
        #2;
        nRST = 1'b1;
        drive(1'b1, 32'hF1, 1'b1, 1'b0);
        step();
        check_outs("post_rst_accept", 1'b1, 32'hF1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_outs("post_rst_drain", 1'b0, 32'h0, 1'b1);

        // Counter behaviour from a clean reset.
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        check("cnt_clr.stall",  {28'd0, stall_cnt},  32'h0);
        check("cnt_clr.bubble", {28'd0, bubble_cnt}, 32'h0);
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step();
`ifdef PIPE_SKID_LATCH_PERF_EN
        check("cnt_mid.stall",  {28'd0, stall_cnt},  32'h3);
        check("cnt_mid.bubble", {28'd0, bubble_cnt}, 32'h1);
`else
        check("cnt_mid.stall",  {28'd0, stall_cnt},  32'h0);
        check("cnt_mid.bubble", {28'd0, bubble_cnt}, 32'h0);
`endif
        for (int c = 0; c < 17; c++) step();
        check_outs("stall_hold", 1'b1, 32'h55, 1'b1);
`ifdef PIPE_SKID_LATCH_PERF_EN
        check("cnt_sat.stall",  {28'd0, stall_cnt},  32'hF);
        check("cnt_sat.bubble", {28'd0, bubble_cnt}, 32'h1);
`else
        check("cnt_sat.stall",  {28'd0, stall_cnt},  32'h0);
        check("cnt_sat.bubble", {28'd0, bubble_cnt}, 32'h0);
`endif
        #2;
        nRST = 1'b0;
        #1;
        check_outs("cnt_rst", 1'b0, 32'h0, 1'b1);
        check("cnt_rst.stall",  {28'd0, stall_cnt},  32'h0);
        check("cnt_rst.bubble", {28'd0, bubble_cnt}, 32'h0);
        #2;
        nRST = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload carried through the stage.
REQ-002 Parameter CNT_W, default 16, width of each performance counter.
REQ-003 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  upstream has payload on in_data.
REQ-006 in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 in_data  in  DATA_W  upstream payload.
REQ-008 flush  in  1  synchronous squash of all held payload.
REQ-009 out_valid  out  1  out_data holds a payload.
REQ-010 out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
REQ-011 out_data  out  DATA_W  payload to downstream.
REQ-012 stall_cnt  out  CNT_W  cycles with out_valid && !out_ready.
REQ-013 bubble_cnt  out  CNT_W  cycles with !out_valid.

Function
REQ-014 Storage SHALL be a main register (drives out_data) plus one skid register, tracked by states EMPTY, ONE, FULL.
REQ-015 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, decoded from state only (no combinational path from out_ready).
REQ-017 EMPTY: input transfer -> ONE, main <= in_data; else stay.
REQ-018 ONE: in and out transfer -> ONE, main <= in_data; in only -> FULL, skid <= in_data; out only -> EMPTY, main <= 0; neither -> hold.
REQ-019 FULL: out transfer -> ONE, main <= skid, skid <= 0; else hold.
REQ-020 Latency SHALL be one cycle from input transfer to out_valid with no backpressure; order SHALL be preserved; no payload dropped or duplicated.
REQ-021 While out_valid && !out_ready, out_data SHALL remain stable.
REQ-022 While out_valid = 0, out_data SHALL be 0.
REQ-023 flush = 1 SHALL take priority: next state EMPTY, main and skid <= 0; an input transfer in that cycle is discarded; an output transfer in that cycle is considered completed.

Reset
REQ-024 nRST low SHALL immediately force state EMPTY, main = 0, skid = 0, stall_cnt = 0, bubble_cnt = 0; hence out_valid = 0, out_data = 0, in_ready = 1.
REQ-025 Reset asserted mid-transfer SHALL discard all held payload; first accept possible on the first posedge after nRST rises.

Configuration
REQ-026 Macro PIPE_SKID_LATCH_PERF_EN: defined -> stall_cnt and bubble_cnt increment by 1 per qualifying cycle, saturate at all-ones, unaffected by flush.
REQ-027 Macro undefined -> stall_cnt and bubble_cnt ports present, tied to 0, no counter flops; data path identical.

Verification
REQ-028 Reset, then in_valid=1, in_data=0x11, out_ready=1 one cycle -> next cycle out_valid=1, out_data=0x11; following cycle out_valid=0, out_data=0.
REQ-029 out_ready=0, send 0xA1 then 0xA2 -> state FULL, in_ready=0, out_data=0xA1 stable; raise out_ready -> 0xA1 then 0xA2 delivered in order, in_ready back to 1 after first drain.
REQ-030 FULL with 0xB1/0xB2, assert flush with out_ready=1 and in_valid=1 (0xB3) -> next cycle out_valid=0, out_data=0, in_ready=1; 0xB3 never appears.
REQ-031 Streaming 0x01..0x08 with out_ready=1 every cycle -> one payload per cycle, 1-cycle latency, in_ready constant 1.
REQ-032 PERF_EN defined, CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cnt saturates at 0xF; nRST pulse mid-test -> counters 0, out_valid=0 immediately.
